// File: rtl/nvdla_sdp_dma_rd_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | nvdla_sdp_dma_rd_responder : SRAM-backed SDP read-DMA endpoint, 32B atoms in, 64B    |
// | beats out, latency-fifo credit flow control. Option: NVDLA_SDP_DMA_RD_RESPONDER_PERF_EN |
// | Rev 1.0                                                                              |
// +--------------------------------------------------------------------------------------+
module nvdla_sdp_dma_rd_responder #(
  parameter int MEM_ATOMS = 1024,
  parameter int REQ_DEPTH = 4,
  parameter int CDT_DEPTH = 16
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rst,
  input  logic                         dma_rd_req_vld,
  output logic                         dma_rd_req_rdy,
  input  logic [78:0]                  dma_rd_req_pd,
  output logic                         dma_rd_rsp_vld,
  input  logic                         dma_rd_rsp_rdy,
  output logic [513:0]                 dma_rd_rsp_pd,
  input  logic                         dma_rd_cdt_lat_fifo_pop,
  input  logic                         mem_wr_en,
  input  logic [$clog2(MEM_ATOMS)-1:0] mem_wr_addr,
  input  logic [255:0]                 mem_wr_data,
  output logic                         idle,
  output logic [31:0]                  err_oor_cnt,
`ifdef NVDLA_SDP_DMA_RD_RESPONDER_PERF_EN
  output logic [31:0]                  perf_rsp_stall_cnt,
  output logic [31:0]                  perf_cdt_stall_cnt,
`endif
  output logic                         cdt_overflow
);
  localparam int AW = $clog2(MEM_ATOMS);
  localparam int QW = $clog2(REQ_DEPTH);
  localparam int CW = $clog2(CDT_DEPTH + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Queue entries keep only {size, atom index}; addr[4:0] carries no information.
  logic [73:0]   q_mem [REQ_DEPTH];
  logic [QW-1:0] q_wr_q, q_rd_q;
  logic [QW:0]   q_cnt_q;
  logic          q_full, q_empty, q_push, q_pop;
  logic [73:0]   q_head;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^dma_rd_req_pd[4:0];
  assign q_full          = (q_cnt_q == (QW+1)'(REQ_DEPTH));
  assign q_empty         = (q_cnt_q == '0);
  assign dma_rd_req_rdy  = !q_full && !nvdla_core_rst;
  assign q_push          = dma_rd_req_vld && dma_rd_req_rdy;
  assign q_head          = q_mem[q_rd_q];

  always_ff @(posedge nvdla_core_clk) begin
    if (q_push) q_mem[q_wr_q] <= {dma_rd_req_pd[78:64], dma_rd_req_pd[63:5]};
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      q_cnt_q <= '0;
    end else begin
      if (q_push) q_wr_q <= q_wr_q + 1'b1;
      if (q_pop)  q_rd_q <= q_rd_q + 1'b1;
      q_cnt_q <= q_cnt_q + (QW+1)'(q_push) - (QW+1)'(q_pop);
    end
  end

  logic [0:0]    state_q, state_d;
  logic [58:0]   cur_q, cur_d, cur_nxt;
  logic [15:0]   rem_q, rem_d, rem_nxt;
  logic [CW-1:0] cdt_q, cdt_d;
  logic          ovf_q, ovf_d;
  logic          vld_q;
  logic [513:0]  pd_q;
  logic [31:0]   err_q, err_d;
  logic [32:0]   err_sum;
  logic          accept, launch, pair, cdt_avail;

  assign accept    = vld_q && dma_rd_rsp_rdy;
  // A beat sitting in the output register has not yet spent its credit.
  assign cdt_avail = (cdt_q > CW'(vld_q));
  assign launch    = (state_q == ST_SEND) && cdt_avail && (!vld_q || dma_rd_rsp_rdy);
  assign pair      = !cur_q[0] && (rem_q >= 16'd2);
  assign rem_nxt   = rem_q - (pair ? 16'd2 : 16'd1);
  assign cur_nxt   = cur_q + (pair ? 59'd2 : 59'd1);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    q_pop   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (!q_empty) begin
        q_pop   = 1'b1;
        state_d = ST_SEND;
        cur_d   = q_head[58:0];
        rem_d   = {1'b0, q_head[73:59]} + 16'd1;
      end
    end else if (launch) begin
      cur_d = cur_nxt;
      rem_d = rem_nxt;
      if (rem_nxt == 16'd0) begin
        // Chain straight into the next burst so back-to-back requests have no bubble.
        if (!q_empty) begin
          q_pop = 1'b1;
          cur_d = q_head[58:0];
          rem_d = {1'b0, q_head[73:59]} + 16'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Even atoms in bank0, odd atoms in bank1: an aligned pair shares one row index.
  logic [255:0]  bank0 [MEM_ATOMS/2];
  logic [255:0]  bank1 [MEM_ATOMS/2];
  logic [AW-2:0] ridx;
  logic          oor;
  logic [255:0]  lo_data, hi_data;

  always_ff @(posedge nvdla_core_clk) begin
    if (mem_wr_en) begin
      if (mem_wr_addr[0]) bank1[mem_wr_addr[AW-1:1]] <= mem_wr_data;
      else                bank0[mem_wr_addr[AW-1:1]] <= mem_wr_data;
    end
  end

  // MEM_ATOMS is even and pairs start even, so both atoms of a pair share one range check.
  assign ridx    = cur_q[AW-1:1];
  assign oor     = (cur_q >= 59'(MEM_ATOMS));
  assign lo_data = oor ? '0 : (cur_q[0] ? bank1[ridx] : bank0[ridx]);
  assign hi_data = (pair && !oor) ? bank1[ridx] : '0;
  assign err_sum = {1'b0, err_q} + ((launch && oor) ? (pair ? 33'd2 : 33'd1) : 33'd0);
  assign err_d   = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];

  always_comb begin
    cdt_d = cdt_q;
    ovf_d = ovf_q;
    if (accept && !dma_rd_cdt_lat_fifo_pop) begin
      cdt_d = cdt_q - 1'b1;
    end else if (dma_rd_cdt_lat_fifo_pop && !accept) begin
      if (cdt_q == CW'(CDT_DEPTH)) ovf_d = 1'b1;
      else                         cdt_d = cdt_q + 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      cdt_q   <= CW'(CDT_DEPTH);
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      pd_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      cdt_q   <= cdt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      if (launch) begin
        vld_q <= 1'b1;
        pd_q  <= {(pair ? 2'b11 : 2'b01), hi_data, lo_data};
      end else if (accept) begin
        vld_q <= 1'b0;
      end
    end
  end

`ifdef NVDLA_SDP_DMA_RD_RESPONDER_PERF_EN
  logic [31:0] rsp_stall_q, cdt_stall_q;
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      rsp_stall_q <= '0;
      cdt_stall_q <= '0;
    end else begin
      if (vld_q && !dma_rd_rsp_rdy && (rsp_stall_q != 32'hFFFF_FFFF))
        rsp_stall_q <= rsp_stall_q + 32'd1;
      if ((state_q == ST_SEND) && (cdt_q == '0) && (cdt_stall_q != 32'hFFFF_FFFF))
        cdt_stall_q <= cdt_stall_q + 32'd1;
    end
  end
  assign perf_rsp_stall_cnt = rsp_stall_q;
  assign perf_cdt_stall_cnt = cdt_stall_q;
`endif

  assign dma_rd_rsp_vld = vld_q;
  assign dma_rd_rsp_pd  = pd_q;
  assign idle           = q_empty && (state_q == ST_IDLE) && !vld_q;
  assign err_oor_cnt    = err_q;
  assign cdt_overflow   = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_nvdla_sdp_dma_rd_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | tb_nvdla_sdp_dma_rd_responder : vector table + scoreboard bench for the read responder |
// | Rev 1.0                                                                              |
// +--------------------------------------------------------------------------------------+
module tb_nvdla_sdp_dma_rd_responder;
  localparam int MEM_ATOMS = 1024;
  localparam int REQ_DEPTH = 4;
  localparam int CDT_DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_vld = 1'b0;
  logic         req_rdy;
  logic [78:0]  req_pd = '0;
  logic         rsp_vld;
  logic         rsp_rdy = 1'b0;
  logic [513:0] rsp_pd;
  logic         pop;
  logic         mem_wr_en = 1'b0;
  logic [9:0]   mem_wr_addr = '0;
  logic [255:0] mem_wr_data = '0;
  logic         idle;
  logic [31:0]  err_oor_cnt;
  logic         cdt_overflow;
  logic         man_pop = 1'b0;
  logic         auto_pop = 1'b0;
`ifdef NVDLA_SDP_DMA_RD_RESPONDER_PERF_EN
  logic [31:0]  perf_rsp_stall_cnt, perf_cdt_stall_cnt;
`endif

  always #5 clk = ~clk;
  // Auto-pop returns a credit in the same cycle the beat is accepted.
  assign pop = man_pop | (auto_pop & rsp_vld & rsp_rdy);

  nvdla_sdp_dma_rd_responder #(
    .MEM_ATOMS(MEM_ATOMS), .REQ_DEPTH(REQ_DEPTH), .CDT_DEPTH(CDT_DEPTH)
  ) dut (
    .nvdla_core_clk         (clk),
    .nvdla_core_rst         (rst),
    .dma_rd_req_vld         (req_vld),
    .dma_rd_req_rdy         (req_rdy),
    .dma_rd_req_pd          (req_pd),
    .dma_rd_rsp_vld         (rsp_vld),
    .dma_rd_rsp_rdy         (rsp_rdy),
    .dma_rd_rsp_pd          (rsp_pd),
    .dma_rd_cdt_lat_fifo_pop(pop),
    .mem_wr_en              (mem_wr_en),
    .mem_wr_addr            (mem_wr_addr),
    .mem_wr_data            (mem_wr_data),
    .idle                   (idle),
    .err_oor_cnt            (err_oor_cnt),
`ifdef NVDLA_SDP_DMA_RD_RESPONDER_PERF_EN
    .perf_rsp_stall_cnt     (perf_rsp_stall_cnt),
    .perf_cdt_stall_cnt     (perf_cdt_stall_cnt),
`endif
    .cdt_overflow           (cdt_overflow)
  );

  typedef struct {
    logic [1:0]   mask;
    logic [511:0] data;
  } beat_t;

  typedef struct {
    logic [63:0]     addr;
    logic [14:0]     size;
    int              nbeats;
    logic [7:0][1:0] masks;
    int              oor;
  } vec_t;

  int           n_checks = 0;
  int           n_fail = 0;
  beat_t        sb[$];
  beat_t        e_mon;
  int           beats_seen = 0;
  int           cyc = 0;
  int           first_acc = -1;
  int           last_acc = -1;
  logic         prev_stall = 1'b0;
  logic [513:0] prev_pd = '0;

  function automatic logic [255:0] atom_data(longint unsigned a);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = {8'(k), 24'(a)};
    return d;
  endfunction

  function automatic logic [255:0] exp_atom(longint unsigned a);
    return (a < MEM_ATOMS) ? atom_data(a) : '0;
  endfunction

  function automatic logic [7:0][1:0] mk(logic [1:0] m0, logic [1:0] m1, logic [1:0] m2, logic [1:0] m3);
    logic [7:0][1:0] r;
    r = '0;
    r[0] = m0; r[1] = m1; r[2] = m2; r[3] = m3;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (!rsp_vld || rsp_pd !== prev_pd) begin
          n_fail++;
          $display("FAIL hold: vld=%0b or payload changed while stalled", rsp_vld);
        end
      end
      if (rsp_vld && rsp_rdy) begin
        beats_seen++;
        last_acc = cyc;
        if (first_acc < 0) first_acc = cyc;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL beat: unexpected beat mask=%b", rsp_pd[513:512]);
        end else begin
          e_mon = sb.pop_front();
          if (rsp_pd !== {e_mon.mask, e_mon.data}) begin
            n_fail++;
            $display("FAIL beat: mask %b exp %b data %h exp %h", rsp_pd[513:512], e_mon.mask,
                     rsp_pd[511:0], e_mon.data);
          end
        end
      end
      prev_stall = rsp_vld && !rsp_rdy;
      prev_pd    = rsp_pd;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_beats(longint unsigned atom0, logic [7:0][1:0] masks, int n);
    longint unsigned a = atom0;
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.mask = masks[j];
      b.data[255:0]   = exp_atom(a);
      b.data[511:256] = masks[j][1] ? exp_atom(a + 1) : '0;
      sb.push_back(b);
      a += masks[j][1] ? 2 : 1;
    end
  endtask

  task automatic push_pairs(longint unsigned atom0, int n);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.mask = 2'b11;
      b.data = {exp_atom(atom0 + 2*j + 1), exp_atom(atom0 + 2*j)};
      sb.push_back(b);
    end
  endtask

  task automatic send_req(logic [63:0] addr, logic [14:0] size);
    bit ok = 0;
    req_vld = 1'b1;
    req_pd  = {size, addr};
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_rdy) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL req_accept: request %0h not accepted within 200 cycles", addr);
    end
  endtask

  task automatic wait_drain(string name, int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && idle) begin done = 1; break; end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: not drained, %0d beats outstanding idle=%0b", name, sb.size(), idle);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vt[7];

  initial begin
    int b0;
    int e0;
    vt[0] = '{addr: 64'h0,         size: 15'd7, nbeats: 4, masks: mk(2'b11, 2'b11, 2'b11, 2'b11), oor: 0};
    vt[1] = '{addr: 64'h60,        size: 15'd5, nbeats: 4, masks: mk(2'b01, 2'b11, 2'b11, 2'b01), oor: 0};
    vt[2] = '{addr: 64'h7FE0,      size: 15'd2, nbeats: 2, masks: mk(2'b01, 2'b11, 2'b00, 2'b00), oor: 2};
    vt[3] = '{addr: 64'h45,        size: 15'd0, nbeats: 1, masks: mk(2'b01, 2'b00, 2'b00, 2'b00), oor: 0};
    vt[4] = '{addr: 64'hA0,        size: 15'd1, nbeats: 2, masks: mk(2'b01, 2'b01, 2'b00, 2'b00), oor: 0};
    vt[5] = '{addr: 64'h100,       size: 15'd3, nbeats: 2, masks: mk(2'b11, 2'b11, 2'b00, 2'b00), oor: 0};
    vt[6] = '{addr: 64'h1_0000_0000, size: 15'd1, nbeats: 1, masks: mk(2'b11, 2'b00, 2'b00, 2'b00), oor: 2};

    step(2);
    chk("rst_req_rdy", 64'(req_rdy), 0);
    chk("rst_rsp_vld", 64'(rsp_vld), 0);
    chk("rst_rsp_pd", 64'(|rsp_pd), 0);
    chk("rst_idle", 64'(idle), 1);
    chk("rst_err", 64'(err_oor_cnt), 0);
    chk("rst_ovf", 64'(cdt_overflow), 0);
    rst = 1'b0;
    step(1);
    chk("post_rst_req_rdy", 64'(req_rdy), 1);

    for (int a = 0; a < MEM_ATOMS; a++) begin
      mem_wr_en = 1'b1; mem_wr_addr = 10'(a); mem_wr_data = atom_data(a);
      step(1);
    end
    mem_wr_en = 1'b0;

    // Table vectors with credits recycled on every accept.
    rsp_rdy = 1'b1; auto_pop = 1'b1;
    for (int v = 0; v < 7; v++) begin
      b0 = beats_seen; e0 = int'(err_oor_cnt);
      push_beats(vt[v].addr >> 5, vt[v].masks, vt[v].nbeats);
      send_req(vt[v].addr, vt[v].size);
      wait_drain($sformatf("vec%0d_drain", v), 100);
      chk($sformatf("vec%0d_beats", v), 64'(beats_seen - b0), 64'(vt[v].nbeats));
      chk($sformatf("vec%0d_oor", v), 64'(int'(err_oor_cnt) - e0), 64'(vt[v].oor));
      chk($sformatf("vec%0d_idle", v), 64'(idle), 1);
    end

    // Credit exhaustion: 40 atoms without pops stops after CDT_DEPTH beats.
    auto_pop = 1'b0;
    b0 = beats_seen;
    push_pairs(0, 20);
    send_req(64'h0, 15'd39);
    step(60);
    chk("cdt_stall_beats", 64'(beats_seen - b0), 16);
    chk("cdt_stall_vld", 64'(rsp_vld), 0);
`ifdef NVDLA_SDP_DMA_RD_RESPONDER_PERF_EN
    chk("perf_cdt_stall", 64'(perf_cdt_stall_cnt > 0), 1);
`endif
    man_pop = 1'b1; step(4); man_pop = 1'b0;
    step(20);
    chk("cdt_resume_beats", 64'(beats_seen - b0), 20);
    chk("cdt_resume_vld", 64'(rsp_vld), 0);
    chk("cdt_resume_sb", 64'(sb.size()), 0);
    man_pop = 1'b1; step(16); man_pop = 1'b0;
    step(1);
    chk("cdt_refill_idle", 64'(idle), 1);
    chk("cdt_refill_ovf", 64'(cdt_overflow), 0);

    // Back-to-back bursts queued behind a stalled response port.
    auto_pop = 1'b1; rsp_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_pairs(64 + 4*k, 2);
      send_req(64'(64 + 4*k) << 5, 15'd3);
    end
    @(negedge clk);
    chk("b2b_req_rdy_full", 64'(req_rdy), 0);
    step(1);
`ifdef NVDLA_SDP_DMA_RD_RESPONDER_PERF_EN
    chk("perf_rsp_stall", 64'(perf_rsp_stall_cnt > 0), 1);
`endif
    b0 = beats_seen; first_acc = -1;
    rsp_rdy = 1'b1;
    wait_drain("b2b_drain", 100);
    chk("b2b_beats", 64'(beats_seen - b0), 10);
    chk("b2b_contiguous", 64'(last_acc - first_acc), 9);

    // Overflowing pop must not add a credit.
    man_pop = 1'b1; step(1); man_pop = 1'b0;
    @(negedge clk);
    chk("ovf_set", 64'(cdt_overflow), 1);
    step(1);
    auto_pop = 1'b0;
    b0 = beats_seen;
    push_pairs(0, 20);
    send_req(64'h0, 15'd39);
    step(60);
    chk("ovf_credits_kept", 64'(beats_seen - b0), 16);

    // Mid-burst reset with a beat held in the output register and a request queued.
    rsp_rdy = 1'b0;
    man_pop = 1'b1; step(2); man_pop = 1'b0;
    step(2);
    chk("pre_rst_vld", 64'(rsp_vld), 1);
    send_req(64'h0, 15'd3);
    rst = 1'b1;
    step(1);
    chk("midrst_vld", 64'(rsp_vld), 0);
    chk("midrst_pd", 64'(|rsp_pd), 0);
    chk("midrst_ovf", 64'(cdt_overflow), 0);
    chk("midrst_err", 64'(err_oor_cnt), 0);
    chk("midrst_idle", 64'(idle), 1);
    chk("midrst_req_rdy", 64'(req_rdy), 0);
    rst = 1'b0;
    sb.delete();
    step(1);
    chk("postrst_req_rdy", 64'(req_rdy), 1);
    rsp_rdy = 1'b1;
    b0 = beats_seen;
    push_pairs(0, 20);
    send_req(64'h0, 15'd39);
    step(60);
    chk("postrst_credits", 64'(beats_seen - b0), 16);
    chk("postrst_vld", 64'(rsp_vld), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
